i2c_burst_writer: RTL and testbench

//  Parametrised I2C write master that extends the single-byte i2c_transmitter.

---
 rtl/i2c_burst_writer.sv | 151 +++++++++++++++
 tb/tb_i2c_burst_writer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_writer.sv
// I2C write master: START, address+W, register byte, streamed data burst, STOP.
// Open-drain SDA with per-byte ACK sampling, NACK abort and divided bit clock.
module i2c_burst_writer #(
  parameter int unsigned CLK_DIV   = 250,
  parameter int unsigned MAX_BYTES = 16,
  localparam int unsigned LEN_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic             fast_clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [6:0]       slave_addr,
  input  logic [7:0]       reg_addr,
  input  logic [LEN_W-1:0] byte_count,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             scl,
  output logic             sda_oe,
  input  logic             sda_in,
  output logic             busy,
  output logic             tx_done,
  output logic             err
);
  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0]    QLast  = QW'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BYTES);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StStart = 4'd1;
  localparam logic [3:0] StAddr  = 4'd2;
  localparam logic [3:0] StAckA  = 4'd3;
  localparam logic [3:0] StReg   = 4'd4;
  localparam logic [3:0] StAckR  = 4'd5;
  localparam logic [3:0] StFetch = 4'd6;
  localparam logic [3:0] StData  = 4'd7;
  localparam logic [3:0] StAckD  = 4'd8;
  localparam logic [3:0] StStop  = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [QW-1:0]    qcnt_q;
  logic [1:0]       quarter_q;
  logic [2:0]       bit_q;
  logic [6:0]       slave_q;
  logic [7:0]       reg_q, data_q, cur_byte;
  logic [LEN_W-1:0] remain_q;
  logic             nack_q, err_q;
  logic             qend, bit_end, last_bit, is_ack;

  assign qend     = (qcnt_q == QLast);
  assign bit_end  = qend && (quarter_q == 2'd3);
  assign last_bit = (bit_q == 3'd7);
  assign is_ack   = (state_q == StAckA) || (state_q == StAckR) || (state_q == StAckD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (tx_en) state_d = StStart;
      StStart: if (bit_end) state_d = StAddr;
      StAddr:  if (bit_end && last_bit) state_d = StAckA;
      StAckA:  if (bit_end) state_d = nack_q ? StStop : StReg;
      StReg:   if (bit_end && last_bit) state_d = StAckR;
      StAckR:  if (bit_end) state_d = (nack_q || remain_q == '0) ? StStop : StFetch;
      StFetch: if (data_valid) state_d = StData;
      StData:  if (bit_end && last_bit) state_d = StAckD;
      StAckD:  if (bit_end) state_d = (nack_q || remain_q == LEN_W'(1)) ? StStop : StFetch;
      StStop:  if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      slave_q   <= 7'd0;
      reg_q     <= 8'd0;
      data_q    <= 8'd0;
      remain_q  <= '0;
      nack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        qcnt_q    <= '0;
        quarter_q <= 2'd0;
        bit_q     <= 3'd0;
        if (tx_en) begin
          slave_q  <= slave_addr;
          reg_q    <= reg_addr;
          remain_q <= (byte_count > MaxLen) ? MaxLen : byte_count;
          err_q    <= 1'b0;
        end
      end else if (state_q == StFetch) begin
        qcnt_q    <= '0;
        quarter_q <= 2'd0;
        if (data_valid) data_q <= data_in;
      end else begin
        qcnt_q <= qend ? '0 : qcnt_q + QW'(1);
        if (qend) quarter_q <= quarter_q + 2'd1;
        if (bit_end) begin
          bit_q <= (state_q == StAddr || state_q == StReg || state_q == StData) ?
                   bit_q + 3'd1 : 3'd0;
          if (state_q == StAckD) remain_q <= remain_q - LEN_W'(1);
        end
        // ACK is taken on the last cycle of the first SCL-high quarter
        if (is_ack && quarter_q == 2'd2 && qend) begin
          nack_q <= sda_in;
          if (sda_in) err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (state_q)
      StAddr:  cur_byte = {slave_q, 1'b0};
      StReg:   cur_byte = reg_q;
      default: cur_byte = data_q;
    endcase
  end

  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      StStart: begin
        scl    = (quarter_q < 2'd2);
        sda_oe = (quarter_q != 2'd0);
      end
      StAddr, StReg, StData: begin
        scl    = quarter_q[1];
        sda_oe = ~cur_byte[3'd7 - bit_q];
      end
      StAckA, StAckR, StAckD: scl = quarter_q[1];
      StFetch: scl = 1'b0;
      StStop: begin
        scl    = (quarter_q != 2'd0);
        sda_oe = (quarter_q < 2'd2);
      end
      default: ;
    endcase
  end

  assign data_ready = (state_q == StFetch);
  assign busy       = (state_q != StIdle);
  assign tx_done    = (state_q == StStop) && bit_end;
  assign err        = err_q;

endmodule

// File: tb/tb_i2c_burst_writer.sv
// Bench for i2c_burst_writer: bus monitor, byte source and slave ACK model checked
// against frame contents and lengths derived from the protocol rules.
module tb_i2c_burst_writer;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_BYTES = 16;
  localparam int unsigned LEN_W     = $clog2(MAX_BYTES + 1);

  logic             fast_clk = 1'b0;
  logic             rst = 1'b1;
  logic             tx_en = 1'b0;
  logic [6:0]       slave_addr = 7'd0;
  logic [7:0]       reg_addr = 8'd0;
  logic [LEN_W-1:0] byte_count = '0;
  logic [7:0]       data_in = 8'd0;
  logic             data_valid = 1'b0;
  logic             data_ready, scl, sda_oe, busy, tx_done, err;
  logic             sda_in = 1'b1;

  i2c_burst_writer #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .fast_clk   (fast_clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .slave_addr (slave_addr),
    .reg_addr   (reg_addr),
    .byte_count (byte_count),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .scl        (scl),
    .sda_oe     (sda_oe),
    .sda_in     (sda_in),
    .busy       (busy),
    .tx_done    (tx_done),
    .err        (err)
  );

  always #5 fast_clk = ~fast_clk;

  int n_compared = 0;
  int n_failed   = 0;

  // monitor state
  int         ncount = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b0, prev_ready = 1'b0;
  int         rises = 0, hi_edges = 0, hs_count = 0, ready_cycles = 0, fetch_viol = 0;
  int         done_count = 0, done_at = 0, nack_group = 0, stall_left = 0;
  logic       err_at_done = 1'b0, hs_now = 1'b0;
  logic       bits[$];
  logic [7:0] hs_data[$];
  logic [7:0] src[$];
  logic [7:0] frame_data[$];

  always @(negedge fast_clk) begin
    ncount++;
    if (scl && !prev_scl) begin
      rises++;
      bits.push_back(!sda_oe);
    end
    if (scl && prev_scl && (sda_oe != prev_sda)) hi_edges++;
    if (data_ready) begin
      ready_cycles++;
      if (scl || (prev_ready && sda_oe != prev_sda)) fetch_viol++;
    end
    hs_now = data_ready && data_valid;
    if (hs_now) begin
      hs_count++;
      hs_data.push_back(data_in);
    end
    if (tx_done) begin
      done_count++;
      done_at     = ncount;
      err_at_done = err;
    end
    // slave: every 9th master bit is the ACK slot; NACK only in the chosen one
    if (rises > 0 && rises % 9 == 0) sda_in = (rises / 9 == nack_group);
    else sda_in = 1'b1;
    prev_scl   = scl;
    prev_sda   = sda_oe;
    prev_ready = data_ready;
  end

  // byte source
  always @(posedge fast_clk) begin
    #1;
    if (hs_now && src.size() > 0) void'(src.pop_front());
    if (data_ready && stall_left > 0) begin
      stall_left--;
      data_valid = 1'b0;
    end else begin
      data_valid = (src.size() > 0);
      data_in    = (src.size() > 0) ? src[0] : 8'h00;
    end
  end

  task automatic clear_monitor(input int nackg, input int stall);
    rises = 0; hi_edges = 0; hs_count = 0; ready_cycles = 0; fetch_viol = 0;
    done_count = 0; nack_group = nackg; stall_left = stall;
    bits.delete();
    hs_data.delete();
    src = frame_data;
  endtask

  task automatic run_frame(input string tag, input logic [6:0] a, input logic [7:0] r,
                           input int cnt, input int nackg, input int stall, input int poke,
                           output int lat);
    int n, groups, hs, exp_len, t0;
    logic [8:0] got9, exp9;
    logic [7:0] eb;
    n       = (cnt > int'(MAX_BYTES)) ? int'(MAX_BYTES) : cnt;
    groups  = (nackg > 0) ? nackg : 2 + n;
    hs      = (groups > 2) ? groups - 2 : 0;
    exp_len = int'(CLK_DIV) * 4 * (2 + 9 * groups) + hs + stall;
    @(posedge fast_clk); #1;
    clear_monitor(nackg, stall);
    slave_addr = a;
    reg_addr   = r;
    byte_count = cnt[LEN_W-1:0];
    tx_en      = 1'b1;
    @(posedge fast_clk);
    t0 = ncount;
    #1;
    tx_en = 1'b0;
    n_compared++;
    if ({busy, err} !== 2'b10) begin
      n_failed++;
      $display("FAIL %s accept: busy,err got %b want 10", tag, {busy, err});
    end
    while (done_count == 0 && ncount - t0 < exp_len + 200) begin
      @(posedge fast_clk); #2;
      tx_en = (poke > 0 && ncount - t0 == poke);
    end
    tx_en = 1'b0;
    lat = done_at - t0;
    n_compared++;
    if (done_count !== 1) begin
      n_failed++;
      $display("FAIL %s done_count: got %0d want 1", tag, done_count);
    end
    n_compared++;
    if (busy !== 1'b0) begin
      n_failed++;
      $display("FAIL %s busy_after_done: got %b want 0", tag, busy);
    end
    n_compared++;
    if (lat !== exp_len) begin
      n_failed++;
      $display("FAIL %s frame_cycles: got %0d want %0d", tag, lat, exp_len);
    end
    n_compared++;
    if (err_at_done !== (nackg > 0)) begin
      n_failed++;
      $display("FAIL %s err_at_done: got %b want %b", tag, err_at_done, nackg > 0);
    end
    n_compared++;
    if (bits.size() !== 9 * groups + 1) begin
      n_failed++;
      $display("FAIL %s bit_count: got %0d want %0d", tag, bits.size(), 9 * groups + 1);
    end
    for (int g = 0; g < groups && 9 * g + 8 < bits.size(); g++) begin
      eb   = (g == 0) ? {a, 1'b0} : (g == 1) ? r : frame_data[g-2];
      exp9 = {eb, 1'b1};
      for (int b = 0; b < 9; b++) got9[8-b] = bits[9*g+b];
      n_compared++;
      if (got9 !== exp9) begin
        n_failed++;
        $display("FAIL %s byte%0d: got %h want %h", tag, g, got9, exp9);
      end
    end
    if (bits.size() > 0) begin
      n_compared++;
      if (bits[bits.size()-1] !== 1'b0) begin
        n_failed++;
        $display("FAIL %s stop_bit: got %b want 0", tag, bits[bits.size()-1]);
      end
    end
    n_compared++;
    if (hs_count !== hs) begin
      n_failed++;
      $display("FAIL %s handshakes: got %0d want %0d", tag, hs_count, hs);
    end
    for (int i = 0; i < hs && i < hs_data.size(); i++) begin
      n_compared++;
      if (hs_data[i] !== frame_data[i]) begin
        n_failed++;
        $display("FAIL %s hs_data%0d: got %h want %h", tag, i, hs_data[i], frame_data[i]);
      end
    end
    n_compared++;
    if (ready_cycles !== hs + stall) begin
      n_failed++;
      $display("FAIL %s ready_cycles: got %0d want %0d", tag, ready_cycles, hs + stall);
    end
    n_compared++;
    if (fetch_viol !== 0) begin
      n_failed++;
      $display("FAIL %s fetch_lines: got %0d want 0", tag, fetch_viol);
    end
    n_compared++;
    if (hi_edges !== 2) begin
      n_failed++;
      $display("FAIL %s sda_edges_scl_high: got %0d want 2", tag, hi_edges);
    end
  endtask

  task automatic fill_data(input int cnt);
    frame_data.delete();
    for (int i = 0; i < cnt; i++) frame_data.push_back(8'($urandom));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge fast_clk);
    #1;
    n_compared++;
    if ({scl, sda_oe, busy, tx_done, err, data_ready} !== 6'b100000) begin
      n_failed++;
      $display("FAIL reset_outputs: got %b want 100000",
               {scl, sda_oe, busy, tx_done, err, data_ready});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    frame_data = '{8'hA5, 8'h5A};
    run_frame("t1", 7'h3C, 8'h40, 2, 0, 0, 0, lat);
    n_compared++;
    if (lat !== 610) begin
      n_failed++;
      $display("FAIL t1_latency: got %0d want 610", lat);
    end
  endtask

  task automatic test_nack;
    int lat;
    fill_data(2);
    run_frame("nack_addr", 7'h3C, 8'h40, 2, 1, 0, 0, lat);
    fill_data(3);
    run_frame("nack_data", 7'($urandom), 8'($urandom), 3, 4, 0, 0, lat);
    // next accepted request must clear err (checked at acceptance)
    fill_data(1);
    run_frame("after_nack", 7'($urandom), 8'($urandom), 1, 0, 0, 0, lat);
  endtask

  task automatic test_stall;
    int lat;
    fill_data(3);
    run_frame("stall", 7'($urandom), 8'($urandom), 3, 0, 100, 0, lat);
  endtask

  task automatic test_boundaries;
    int lat;
    fill_data(0);
    run_frame("pointer_only", 7'($urandom), 8'($urandom), 0, 0, 0, 0, lat);
    fill_data(MAX_BYTES + 5);
    run_frame("clamped", 7'($urandom), 8'($urandom), MAX_BYTES + 5, 0, 0, 0, lat);
  endtask

  task automatic test_random;
    int lat, cnt, nackg;
    for (int k = 0; k < 6; k++) begin
      cnt   = $urandom_range(6);
      nackg = ($urandom_range(3) == 0) ? $urandom_range(2 + cnt, 1) : 0;
      fill_data(cnt);
      run_frame("random", 7'($urandom), 8'($urandom), cnt, nackg, 0, 0, lat);
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    fill_data(3);
    @(posedge fast_clk); #1;
    clear_monitor(0, 0);
    slave_addr = 7'h2A;
    reg_addr   = 8'h11;
    byte_count = LEN_W'(3);
    tx_en      = 1'b1;
    @(posedge fast_clk); #1;
    tx_en = 1'b0;
    t0 = ncount;
    while (hs_count == 0 && ncount - t0 < 2000) begin
      @(posedge fast_clk); #1;
    end
    n_compared++;
    if (hs_count < 1) begin
      n_failed++;
      $display("FAIL reset_mid_reach_data: got %0d handshakes want >=1", hs_count);
    end
    repeat (30) @(posedge fast_clk);
    #1;
    rst = 1'b1;
    @(posedge fast_clk); #1;
    n_compared++;
    if ({scl, sda_oe, busy} !== 3'b100) begin
      n_failed++;
      $display("FAIL reset_mid_lines: got %b want 100", {scl, sda_oe, busy});
    end
    rst = 1'b0;
    repeat (300) @(posedge fast_clk);
    #1;
    n_compared++;
    if ({done_count != 0, busy} !== 2'b00) begin
      n_failed++;
      $display("FAIL reset_mid_no_stop: done=%0d busy=%b want 0,0", done_count, busy);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    fill_data(2);
    run_frame("busy_tx_en", 7'($urandom), 8'($urandom), 2, 0, 0, 50, lat);
    repeat (100) @(posedge fast_clk);
    #1;
    n_compared++;
    if ({busy, done_count} !== {1'b0, 32'sd1}) begin
      n_failed++;
      $display("FAIL busy_ignore_second: busy=%b done=%0d want 0,1", busy, done_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nack();
    test_stall();
    test_boundaries();
    test_random();
    test_reset_mid();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
